mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access (MEM) stage of the 5-stage processor pipeline, directly downstream of the EX/MEM pipeline register. It consumes the EX/MEM control and data outputs and runs loads and stores over a request/ready data-memory handshake. It stalls the upstream pipeline while an access is outstanding and registers the result into the MEM/WB outputs consumed by write-back. Branch redirect information is forwarded combinationally to the fetch stage.

## Interface
- ADDR_W, 8, data-memory word-address width; memAddr = inALUResult[ADDR_W-1:0]
- TIMEOUT_CYCLES, 16, max WAIT cycles before abort (only with MEM_TIMEOUT_EN); must be >= 1
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- inBranchTaken / inBranchTarget  input  1 / 8  branch resolution from EX/MEM
- inMemToReg, inRegWrite, inMemRead, inMemWrite  input  1 each  control from EX/MEM
- inALUResult  input  32  address for loads/stores, result for ALU ops
- inWriteData  input  32  store data
- inWriteReg  input  5  destination register
- memReq  output  1  registered access request
- memWe  output  1  registered, 1 = store
- memAddr  output  ADDR_W  registered word address
- memWData  output  32  registered store data
- memReady  input  1  memory completes access in this cycle (sampled only while memReq=1)
- memRData  input  32  load data, valid when memReady=1
- outStall  output  1  combinational; 1 = EX/MEM and earlier stages must hold
- outPCSrc  output  1  combinational, inBranchTaken & ~outStall
- outPCTarget  output  8  combinational, inBranchTarget
- outMemToReg, outRegWrite  output  1 each  MEM/WB control
- outReadData, outALUResult  output  32 each  MEM/WB data
- outWriteReg  output  5  MEM/WB destination
- outMemError  output  1  sticky access-timeout flag

## Operation
- FSM states: IDLE, WAIT. Reset state IDLE.
- Access = inMemRead | inMemWrite. If both are set, the access is a store (write wins); outReadData is loaded with 0.
- IDLE, no access: outStall=0; MEM/WB loads inMemToReg, inRegWrite, inALUResult, inWriteReg; outReadData <= 0.
- IDLE, access: outStall=1. On the edge: memReq<=1, memWe<=inMemWrite, memAddr/memWData latched, and the EX/MEM control is copied to internal holding registers. MEM/WB loads a bubble (outRegWrite=0, outMemToReg=0). Next state is WAIT.
- WAIT: memReq=1, and addr, we and wdata are held stable. outStall = ~memReady.
- WAIT with memReady=1 (EX/MEM still holds the same instruction):
  - MEM/WB loads the held control, outALUResult, outWriteReg, and outReadData = memRData for loads or 0 for stores.
  - memReq<=0; next state is IDLE.
- memReady while memReq=0 is ignored.
- No new request is issued in the cycle immediately following completion unless the instruction then in EX/MEM is an access. In that case the IDLE-access path applies, giving back-to-back requests separated by one memReq-low cycle.

## Timing
- Reset values: memReq=0, memWe=0, memAddr=0, memWData=0, all MEM/WB outputs 0, outMemError=0, state IDLE. A reset mid-access abandons it; memReq drops on the reset edge.
- Non-memory instruction: 1-cycle latency EX/MEM to MEM/WB, no stall.
- Memory instruction with memReady in the first WAIT cycle: stall lasts 1 cycle, and the result appears in MEM/WB 2 cycles after entry. Each extra wait cycle adds 1 to both.
- outPCSrc is suppressed while stalled. A branch held in EX/MEM during a stall is presented when the stall clears.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on WAIT entry and increments each WAIT cycle without memReady.
  - When it reaches TIMEOUT_CYCLES: memReq<=0, MEM/WB loads a bubble (outRegWrite=0), outMemError<=1 (held until rst), next state IDLE, outStall=0 in that cycle.
  - memReady in the same cycle as the timeout wins (normal completion).
- MEM_TIMEOUT_EN undefined: no counter, outMemError tied 0, WAIT persists indefinitely.

## Test plan
- ALU op (inRegWrite=1, inALUResult=0x0000_1234, inWriteReg=5): next cycle outRegWrite=1, outALUResult=0x1234, outWriteReg=5, outStall never 1.
- Load from address 0x10, memReady on the 3rd WAIT cycle, memRData=0xDEAD_BEEF: outStall high 3 cycles; memReq=1 with memAddr=0x10 and memWe=0; then outReadData=0xDEADBEEF and outMemToReg=1.
- Store (inMemWrite=1, inWriteData=0xA5A5_A5A5, address 0x22), immediate ready: one stall cycle; memWe=1, memWData=0xA5A5A5A5; MEM/WB outRegWrite=0.
- Load followed directly by store: two distinct memReq pulses separated by one low cycle; each has correct address and data.
- rst asserted in WAIT: next cycle memReq=0, outStall=0, all outputs 0, state IDLE.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, memReady held 0: memReq drops after 4 WAIT cycles, outMemError=1 and stays 1, bubble written to MEM/WB.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage pipeline.
// Runs loads/stores over a memReq/memReady handshake, stalls upstream while
// an access is outstanding and registers results into the MEM/WB outputs.
// Optional feature macro: MEM_TIMEOUT_EN (aborts a WAIT after TIMEOUT_CYCLES).
module mem_access_stage #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inBranchTaken,
    input  logic [7:0]        inBranchTarget,
    input  logic              inMemToReg,
    input  logic              inRegWrite,
    input  logic              inMemRead,
    input  logic              inMemWrite,
    input  logic [31:0]       inALUResult,
    input  logic [31:0]       inWriteData,
    input  logic [4:0]        inWriteReg,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWData,
    input  logic              memReady,
    input  logic [31:0]       memRData,
    output logic              outStall,
    output logic              outPCSrc,
    output logic [7:0]        outPCTarget,
    output logic              outMemToReg,
    output logic              outRegWrite,
    output logic [31:0]       outReadData,
    output logic [31:0]       outALUResult,
    output logic [4:0]        outWriteReg,
    output logic              outMemError
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_nxt_state;
    logic        w_access;
    logic        w_issue;
    logic        w_complete;
    logic        w_abort;
    logic        w_tmo_hit;

    // Copy of the in-flight instruction's EX/MEM fields, written at issue.
    logic        r_hold_mem_to_reg;
    logic        r_hold_reg_write;
    logic        r_hold_is_load;
    logic [31:0] r_hold_alu_result;
    logic [4:0]  r_hold_write_reg;

    assign w_access = inMemRead | inMemWrite;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_tmo_cnt;

    // The current WAIT cycle is the TIMEOUT_CYCLES-th one without memReady.
    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

    // Wait-cycle counter: cleared at issue, advanced on each unready WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= 8'd0;
        end else if (w_issue) begin
            r_tmo_cnt <= 8'd0;
        end else if ((r_state == WAIT) && !memReady) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end else begin
            r_tmo_cnt <= r_tmo_cnt;
        end
    end

    // Sticky error flag set when an access is abandoned by timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            outMemError <= 1'b0;
        end else if (w_abort) begin
            outMemError <= 1'b1;
        end else begin
            outMemError <= outMemError;
        end
    end
`else
    assign w_tmo_hit   = 1'b0;
    assign outMemError = 1'b0;
`endif

    // Next-state and handshake strobes; memReady has priority over timeout.
    always_comb begin
        w_nxt_state = r_state;
        w_issue     = 1'b0;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_issue     = 1'b1;
                    w_nxt_state = WAIT;
                end else begin
                    w_nxt_state = IDLE;
                end
            end
            WAIT: begin
                if (memReady) begin
                    w_complete  = 1'b1;
                    w_nxt_state = IDLE;
                end else if (w_tmo_hit) begin
                    w_abort     = 1'b1;
                    w_nxt_state = IDLE;
                end else begin
                    w_nxt_state = WAIT;
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // Stall holds EX/MEM until the access finishes; branches wait it out.
    always_comb begin
        outStall    = w_issue | ((r_state == WAIT) & ~w_complete & ~w_abort);
        outPCSrc    = inBranchTaken & ~outStall;
        outPCTarget = inBranchTarget;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Memory request port, holding registers and MEM/WB pipeline outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            memReq            <= 1'b0;
            memWe             <= 1'b0;
            memAddr           <= '0;
            memWData          <= 32'd0;
            r_hold_mem_to_reg <= 1'b0;
            r_hold_reg_write  <= 1'b0;
            r_hold_is_load    <= 1'b0;
            r_hold_alu_result <= 32'd0;
            r_hold_write_reg  <= 5'd0;
            outMemToReg       <= 1'b0;
            outRegWrite       <= 1'b0;
            outReadData       <= 32'd0;
            outALUResult      <= 32'd0;
            outWriteReg       <= 5'd0;
        end else if (w_issue) begin
            memReq            <= 1'b1;
            memWe             <= inMemWrite;
            memAddr           <= inALUResult[ADDR_W-1:0];
            memWData          <= inWriteData;
            r_hold_mem_to_reg <= inMemToReg;
            r_hold_reg_write  <= inRegWrite;
            r_hold_is_load    <= inMemRead & ~inMemWrite;
            r_hold_alu_result <= inALUResult;
            r_hold_write_reg  <= inWriteReg;
            outMemToReg       <= 1'b0;
            outRegWrite       <= 1'b0;
            outReadData       <= 32'd0;
            outALUResult      <= 32'd0;
            outWriteReg       <= 5'd0;
        end else if (w_complete) begin
            memReq            <= 1'b0;
            outMemToReg       <= r_hold_mem_to_reg;
            outRegWrite       <= r_hold_reg_write;
            outReadData       <= r_hold_is_load ? memRData : 32'd0;
            outALUResult      <= r_hold_alu_result;
            outWriteReg       <= r_hold_write_reg;
        end else if (w_abort) begin
            memReq            <= 1'b0;
            outMemToReg       <= 1'b0;
            outRegWrite       <= 1'b0;
            outReadData       <= 32'd0;
            outALUResult      <= 32'd0;
            outWriteReg       <= 5'd0;
        end else if (r_state == IDLE) begin
            outMemToReg       <= inMemToReg;
            outRegWrite       <= inRegWrite;
            outReadData       <= 32'd0;
            outALUResult      <= inALUResult;
            outWriteReg       <= inWriteReg;
        end else begin
            memReq            <= memReq;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inBranchTaken;
    logic [7:0]  inBranchTarget;
    logic        inMemToReg, inRegWrite, inMemRead, inMemWrite;
    logic [31:0] inALUResult, inWriteData;
    logic [4:0]  inWriteReg;
    logic        memReq, memWe;
    logic [7:0]  memAddr;
    logic [31:0] memWData;
    logic        memReady;
    logic [31:0] memRData;
    logic        outStall, outPCSrc;
    logic [7:0]  outPCTarget;
    logic        outMemToReg, outRegWrite;
    logic [31:0] outReadData, outALUResult;
    logic [4:0]  outWriteReg;
    logic        outMemError;

    int vectors = 0;
    int miscompares = 0;

    mem_access_stage #(.ADDR_W(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .inBranchTaken(inBranchTaken), .inBranchTarget(inBranchTarget),
        .inMemToReg(inMemToReg), .inRegWrite(inRegWrite),
        .inMemRead(inMemRead), .inMemWrite(inMemWrite),
        .inALUResult(inALUResult), .inWriteData(inWriteData), .inWriteReg(inWriteReg),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memReady(memReady), .memRData(memRData),
        .outStall(outStall), .outPCSrc(outPCSrc), .outPCTarget(outPCTarget),
        .outMemToReg(outMemToReg), .outRegWrite(outRegWrite),
        .outReadData(outReadData), .outALUResult(outALUResult),
        .outWriteReg(outWriteReg), .outMemError(outMemError)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        inBranchTaken = 1'b0; inBranchTarget = 8'h00;
        inMemToReg = 1'b0; inRegWrite = 1'b0; inMemRead = 1'b0; inMemWrite = 1'b0;
        inALUResult = 32'h0; inWriteData = 32'h0; inWriteReg = 5'd0;
    endtask

    initial begin
        rst = 1'b1; nop(); memReady = 1'b0; memRData = 32'h0;
        step(); step();
        check("rst_memReq", {31'd0, memReq}, 32'd0);
        check("rst_memAddr", {24'd0, memAddr}, 32'd0);
        check("rst_stall", {31'd0, outStall}, 32'd0);
        check("rst_regwrite", {31'd0, outRegWrite}, 32'd0);
        check("rst_alu", outALUResult, 32'd0);
        check("rst_err", {31'd0, outMemError}, 32'd0);

        // ALU op
        rst = 1'b0;
        inRegWrite = 1'b1; inALUResult = 32'h0000_1234; inWriteReg = 5'd5;
        #1 check("alu_stall0", {31'd0, outStall}, 32'd0);
        step();
        check("alu_regwrite", {31'd0, outRegWrite}, 32'd1);
        check("alu_result", outALUResult, 32'h0000_1234);
        check("alu_wreg", {27'd0, outWriteReg}, 32'd5);
        check("alu_stall1", {31'd0, outStall}, 32'd0);
        check("alu_noreq", {31'd0, memReq}, 32'd0);

        // Branch with no access goes straight through
        nop(); inBranchTaken = 1'b1; inBranchTarget = 8'h5A;
        #1 check("br_pcsrc", {31'd0, outPCSrc}, 32'd1);
        check("br_target", {24'd0, outPCTarget}, 32'h5A);

        // Load from 0x10 with memReady on the 3rd WAIT cycle (branch also held)
        inMemRead = 1'b1; inMemToReg = 1'b1; inRegWrite = 1'b1;
        inALUResult = 32'h0000_0010; inWriteReg = 5'd7;
        #1 check("ld_stall_idle", {31'd0, outStall}, 32'd1);
        check("ld_pcsrc_supp", {31'd0, outPCSrc}, 32'd0);
        step();
        check("ld_req", {31'd0, memReq}, 32'd1);
        check("ld_addr", {24'd0, memAddr}, 32'h10);
        check("ld_we", {31'd0, memWe}, 32'd0);
        check("ld_bubble", {31'd0, outRegWrite}, 32'd0);
        check("ld_stall_w1", {31'd0, outStall}, 32'd1);
        step();
        check("ld_stall_w2", {31'd0, outStall}, 32'd1);
        check("ld_req_w2", {31'd0, memReq}, 32'd1);
        step();
        memReady = 1'b1; memRData = 32'hDEAD_BEEF;
        #1 check("ld_stall_w3", {31'd0, outStall}, 32'd0);
        check("ld_pcsrc_rel", {31'd0, outPCSrc}, 32'd1);
        step();
        nop(); memReady = 1'b0; memRData = 32'h0;
        check("ld_req_drop", {31'd0, memReq}, 32'd0);
        check("ld_rdata", outReadData, 32'hDEAD_BEEF);
        check("ld_memtoreg", {31'd0, outMemToReg}, 32'd1);
        check("ld_regwrite", {31'd0, outRegWrite}, 32'd1);
        check("ld_wreg", {27'd0, outWriteReg}, 32'd7);

        // memReady while memReq=0 is ignored
        memReady = 1'b1; memRData = 32'h5555_5555;
        step();
        check("ign_req", {31'd0, memReq}, 32'd0);
        check("ign_rdata", outReadData, 32'd0);
        memReady = 1'b0;

        // Store to 0x22, immediate ready
        inMemWrite = 1'b1; inWriteData = 32'hA5A5_A5A5; inALUResult = 32'h0000_0022;
        #1 check("st_stall", {31'd0, outStall}, 32'd1);
        step();
        check("st_req", {31'd0, memReq}, 32'd1);
        check("st_we", {31'd0, memWe}, 32'd1);
        check("st_wdata", memWData, 32'hA5A5_A5A5);
        check("st_addr", {24'd0, memAddr}, 32'h22);
        memReady = 1'b1;
        #1 check("st_stall_clr", {31'd0, outStall}, 32'd0);
        step();
        nop(); memReady = 1'b0;
        check("st_req_drop", {31'd0, memReq}, 32'd0);
        check("st_regwrite", {31'd0, outRegWrite}, 32'd0);
        check("st_rdata", outReadData, 32'd0);

        // Load (0x30) directly followed by store (0x31)
        inMemRead = 1'b1; inMemToReg = 1'b1; inRegWrite = 1'b1;
        inALUResult = 32'h0000_0030; inWriteReg = 5'd3;
        step();
        check("b2b_ld_req", {31'd0, memReq}, 32'd1);
        check("b2b_ld_addr", {24'd0, memAddr}, 32'h30);
        memReady = 1'b1; memRData = 32'h1122_3344;
        step();
        nop(); memReady = 1'b0;
        inMemWrite = 1'b1; inALUResult = 32'h0000_0031; inWriteData = 32'hCAFE_F00D;
        #1 check("b2b_gap", {31'd0, memReq}, 32'd0);
        check("b2b_gap_stall", {31'd0, outStall}, 32'd1);
        check("b2b_ld_rdata", outReadData, 32'h1122_3344);
        check("b2b_ld_wreg", {27'd0, outWriteReg}, 32'd3);
        step();
        check("b2b_st_req", {31'd0, memReq}, 32'd1);
        check("b2b_st_we", {31'd0, memWe}, 32'd1);
        check("b2b_st_addr", {24'd0, memAddr}, 32'h31);
        check("b2b_st_wdata", memWData, 32'hCAFE_F00D);
        memReady = 1'b1;
        step();
        nop(); memReady = 1'b0;
        check("b2b_st_drop", {31'd0, memReq}, 32'd0);

        // Reset in WAIT
        inMemRead = 1'b1; inRegWrite = 1'b1; inALUResult = 32'h0000_0044; inWriteReg = 5'd9;
        step();
        check("rw_req", {31'd0, memReq}, 32'd1);
        rst = 1'b1; nop();
        step();
        check("rw_req0", {31'd0, memReq}, 32'd0);
        check("rw_stall0", {31'd0, outStall}, 32'd0);
        check("rw_addr0", {24'd0, memAddr}, 32'd0);
        check("rw_rdata0", outReadData, 32'd0);
        check("rw_wreg0", {27'd0, outWriteReg}, 32'd0);
        rst = 1'b0;
        inRegWrite = 1'b1; inALUResult = 32'h0000_0077; inWriteReg = 5'd2;
        #1 check("rw_idle_stall", {31'd0, outStall}, 32'd0);
        step();
        check("rw_idle_alu", outALUResult, 32'h0000_0077);
        nop();

`ifdef MEM_TIMEOUT_EN
        // Timeout after 4 WAIT cycles with memReady held low
        inMemRead = 1'b1; inRegWrite = 1'b1; inMemToReg = 1'b1;
        inALUResult = 32'h0000_0050; inWriteReg = 5'd4;
        step();
        check("to_w1_req", {31'd0, memReq}, 32'd1);
        check("to_w1_stall", {31'd0, outStall}, 32'd1);
        step();
        check("to_w2_stall", {31'd0, outStall}, 32'd1);
        step();
        check("to_w3_stall", {31'd0, outStall}, 32'd1);
        step();
        check("to_w4_req", {31'd0, memReq}, 32'd1);
        check("to_w4_stall", {31'd0, outStall}, 32'd0);
        step();
        nop();
        check("to_req_drop", {31'd0, memReq}, 32'd0);
        check("to_err", {31'd0, outMemError}, 32'd1);
        check("to_bubble", {31'd0, outRegWrite}, 32'd0);
        step(); step();
        check("to_err_sticky", {31'd0, outMemError}, 32'd1);
`else
        // Without timeout the WAIT state persists
        inMemRead = 1'b1; inALUResult = 32'h0000_0050;
        step();
        for (int i = 0; i < 20; i++) step();
        check("nto_req", {31'd0, memReq}, 32'd1);
        check("nto_stall", {31'd0, outStall}, 32'd1);
        check("nto_err", {31'd0, outMemError}, 32'd0);
        memReady = 1'b1; memRData = 32'h0BAD_F00D;
        step();
        nop(); memReady = 1'b0;
        check("nto_rdata", outReadData, 32'h0BAD_F00D);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
